magnetron_pwm_ctrl: RTL
=======================

Name: magnetron_pwm_ctrl

Overview:
Clocked, parametrised successor to the combinational magnetron Set/Reset logic. It keeps the same start/stop/clear/door/timer-done priority and adds a cook/pause state machine. It also adds power-level duty cycling of the magnetron over a configurable period of timer ticks. It sits between the front-panel/door inputs and the timer on one side and the magnetron driver (Set/Reset latch) on the other.

Parameters:
PWR_W, 2, width of power-level select; 2^PWR_W power levels
PERIOD, 8, duty-cycle period in tick strobes (2..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
comecaN  in  1  start button, active low
pareN  in  1  stop/pause button, active low
limpaN  in  1  clear button, active low
portafechada  in  1  1 = door closed
tdone  in  1  cook timer expired (level)
tick  in  1  one-cycle duty-period strobe from prescaler
potencia  in  PWR_W  requested power level, 0 = lowest
Set  out  1  magnetron latch set (energise)
Reset  out  1  magnetron latch reset; always equals !Set
estado  out  2  state: 0 IDLE, 1 COOK, 2 PAUSE
fase  out  8  current duty phase counter

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset dominates all inputs.
- On reset: state IDLE, Set=0, Reset=1, fase=0, pwr_reg=0, comecaN_d=1.
- Start event: start_evt = comecaN_d & !comecaN, a registered falling edge. Holding comecaN low produces exactly one event.
- IDLE to COOK: start_evt & portafechada & !tdone. On this transition: latch pwr_reg<=potencia and set fase<=0.
- COOK exits, in priority order:
  - !limpaN -> IDLE
  - tdone -> IDLE
  - !pareN -> PAUSE
  - !portafechada -> PAUSE
- PAUSE exits, in priority order:
  - !limpaN -> IDLE
  - tdone -> IDLE
  - start_evt & portafechada & pareN -> COOK
- Resume from PAUSE keeps fase and pwr_reg. potencia changes are ignored until the next start from IDLE.
- IDLE clears fase to 0 every cycle.
- Phase counter: in COOK only, when tick=1, fase <= (fase==PERIOD-1) ? 0 : fase+1. Held in PAUSE.
- On time: on_ticks = ((pwr_reg+1)*PERIOD) >> PWR_W. Intermediate width is PWR_W+9 bits, so there is no overflow. The maximum level gives on_ticks=PERIOD (continuous).
- energise = (next_state==COOK) & (next_fase < on_ticks) & portafechada.
- Outputs are registered: Set <= energise, Reset <= !energise.
- Latency: any input change reaches Set/Reset on the following rising edge (1 cycle). Set and Reset are never equal.
- Simultaneous events: clear beats tdone, which beats stop, which beats door-open, which beats start. A start_evt in the same cycle as !pareN, !limpaN or tdone is discarded.
- on_ticks=0 (only possible if PERIOD < 2^PWR_W): magnetron never energised but state still COOK. Documented as misconfiguration.

Optional Feature:
Macro DOOR_INTERLOCK_EN.
- Defined: Set output = Set_reg & portafechada, and Reset = !Set. Opening the door drops Set combinationally in the same cycle, with zero-cycle cutoff, while the state machine still moves to PAUSE on the next edge.
- Undefined: Set/Reset are purely registered, with a 1-cycle cutoff after the door opens.

Test Plan:
1. PWR_W=2, PERIOD=8, potencia=1, door closed, pulse comecaN low 1 cycle -> estado=COOK next cycle. Set=1 for fase 0..3 and Set=0 for fase 4..7 (on_ticks=4). The pattern repeats every 8 ticks.
2. potencia=3 in COOK -> Set stays 1 for all fase. Change potencia to 0 mid-cook -> duty unchanged (pwr_reg latched).
3. COOK at fase=5, open door -> estado=PAUSE, Set=0 one cycle later (same cycle with DOOR_INTERLOCK_EN), fase held at 5. Close door and pulse comecaN -> COOK resumes from fase=5.
4. COOK with comecaN held low 20 cycles, then pareN low -> PAUSE. No re-entry to COOK until comecaN rises and falls again.
5. Simultaneous limpaN=0, tdone=1, start_evt in COOK -> IDLE, Set=0, Reset=1, fase=0.
6. Assert rst mid-COOK with Set=1 -> next edge IDLE, Set=0, Reset=1, fase=0. Start attempt with door open in IDLE -> stays IDLE.

Source files
------------

// File: rtl/magnetron_pwm_ctrl.sv
// Magnetron Set/Reset controller: start/stop/clear/door/timer priority, cook/pause FSM, power duty.
// Define DOOR_INTERLOCK_EN to gate Set with the door switch combinationally (zero-cycle cutoff).
module magnetron_pwm_ctrl #(
    parameter int unsigned PWR_W  = 2,
    parameter int unsigned PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comecaN,
    input  logic             pareN,
    input  logic             limpaN,
    input  logic             portafechada,
    input  logic             tdone,
    input  logic             tick,
    input  logic [PWR_W-1:0] potencia,
    output logic             Set,
    output logic             Reset,
    output logic [1:0]       estado,
    output logic [7:0]       fase
);

    // Wide enough for (2^PWR_W) * 255 with no overflow.
    localparam int unsigned OW = PWR_W + 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCook  = 2'd1,
        StPause = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       fase_q, fase_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic             comeca_q;
    logic             set_q;
    logic             start_evt;
    logic             fase_wrap;
    logic [OW-1:0]    on_ticks;
    logic             energise;

    assign start_evt = comeca_q & ~comecaN;
    assign fase_wrap = (fase_q == 8'(PERIOD - 1));

    // Priority: clear > tdone > stop > door-open > start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_evt && portafechada && !tdone && pareN && limpaN) begin
                    state_d = StCook;
                end
            end
            StCook: begin
                if (!limpaN || tdone) begin
                    state_d = StIdle;
                end else if (!pareN || !portafechada) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (!limpaN || tdone) begin
                    state_d = StIdle;
                end else if (start_evt && portafechada && pareN) begin
                    state_d = StCook;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pwr_d  = pwr_q;
        fase_d = fase_q;
        if (state_q == StIdle && state_d == StCook) begin
            pwr_d = potencia;
        end
        if (state_q == StIdle || state_d == StIdle) begin
            fase_d = 8'd0;
        end else if (state_q == StCook && tick) begin
            fase_d = fase_wrap ? 8'd0 : fase_q + 8'd1;
        end
    end

    // Duty decision looks at next-cycle state so Set tracks inputs with one cycle of latency.
    always_comb begin
        on_ticks = ((OW'(pwr_d) + OW'(1)) * OW'(PERIOD)) >> PWR_W;
        energise = (state_d == StCook) && (OW'(fase_d) < on_ticks) && portafechada;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            fase_q   <= 8'd0;
            pwr_q    <= '0;
            comeca_q <= 1'b1;
            set_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fase_q   <= fase_d;
            pwr_q    <= pwr_d;
            comeca_q <= comecaN;
            set_q    <= energise;
        end
    end

`ifdef DOOR_INTERLOCK_EN
    assign Set = set_q & portafechada;
`else
    assign Set = set_q;
`endif
    assign Reset  = ~Set;
    assign estado = state_q;
    assign fase   = fase_q;

endmodule
